// File: rtl/pc_redirect_unit_pkg.sv
// Shared decode constants, FSM encoding and redirect priorities for the fetch PC redirect logic.
package pc_redirect_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    typedef logic [1:0] pri_t;
    localparam pri_t PRI_NONE   = 2'd0;
    localparam pri_t PRI_JUMP   = 2'd1;
    localparam pri_t PRI_BRANCH = 2'd2;

    localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/pc_redirect_unit_if.sv
// Pipeline-facing signal bundle of pc_redirect_unit; slave is the unit, master the surrounding pipeline.
interface pc_redirect_unit_if #(parameter int ADDR_W = 32);
    logic              stall;
    logic [31:0]       idInstr;
    logic              idValid;
    logic [ADDR_W-1:0] idPc;
    logic [ADDR_W-1:0] regRs;
    logic              brTaken;
    logic [ADDR_W-1:0] brTarget;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pcPlus4;
    logic              redirect;
    logic              flush;
    logic              flushEx;
    logic              misalign;

    modport master (
        output stall, idInstr, idValid, idPc, regRs, brTaken, brTarget,
        input  pc, pcPlus4, redirect, flush, flushEx, misalign
    );

    modport slave (
        input  stall, idInstr, idValid, idPc, regRs, brTaken, brTarget,
        output pc, pcPlus4, redirect, flush, flushEx, misalign
    );
endinterface

// File: rtl/pc_redirect_unit_jump_decode.sv
// Combinational redirect request decode: EX taken branch beats JR/JALR, which beats J/JAL.
module jump_decode
    import pc_redirect_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [31:0]       idInstr,
    input  logic              idValid,
    input  logic [ADDR_W-1:0] idPc,
    input  logic [ADDR_W-1:0] regRs,
    input  logic              brTaken,
    input  logic [ADDR_W-1:0] brTarget,
    output logic              reqValid,
    output pri_t              reqPri,
    output logic [ADDR_W-1:0] reqTarget
);
    logic [5:0]        op;
    logic [5:0]        fn;
    logic              is_jr;
    logic              is_j;
    logic [ADDR_W-1:0] j_target;
    logic              unused_pc_lo;

    assign op    = idInstr[31:26];
    assign fn    = idInstr[5:0];
    assign is_jr = idValid && (op == OP_RTYPE) && (fn == FN_JR || fn == FN_JALR);
    assign is_j  = idValid && (op == OP_J || op == OP_JAL);

    // J/JAL keeps the 256MB region of the jump itself
    generate
        if (ADDR_W > 28) begin : g_region
            assign j_target = {idPc[ADDR_W-1:28], idInstr[25:0], 2'b00};
        end else begin : g_flat
            assign j_target = {idInstr[25:0], 2'b00};
        end
    endgenerate

    assign unused_pc_lo = ^idPc[27:0];

    always_comb begin
        reqValid  = 1'b1;
        reqPri    = PRI_BRANCH;
        reqTarget = brTarget;
        if (brTaken) begin
            reqPri    = PRI_BRANCH;
            reqTarget = brTarget;
        end else if (is_jr) begin
            reqPri    = PRI_JUMP;
            reqTarget = regRs;
        end else if (is_j) begin
            reqPri    = PRI_JUMP;
            reqTarget = j_target;
        end else begin
            reqValid  = 1'b0;
            reqPri    = PRI_NONE;
        end
    end
endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with redirect arbitration, stall-time redirect hold and multi-cycle flush.
// Optional misaligned-target trap enabled by defining PC_REDIRECT_ALIGN_CHECK_EN.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int                FLUSH_CYCLES = 1,
    parameter logic [ADDR_W-1:0] TRAP_VEC     = ADDR_W'(32'h0000_0080)
) (
    input logic               clk,
    input logic               reset,
    pc_redirect_unit_if.slave bus
);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);
    localparam logic [ADDR_W-1:0]      PC_STEP    = ADDR_W'(4);

    logic                   req_valid;
    pri_t                   req_pri;
    logic [ADDR_W-1:0]      req_target;

    logic [0:0]             state;
    logic [ADDR_W-1:0]      pc_q;
    logic [ADDR_W-1:0]      pend_target;
    pri_t                   pend_pri;
    logic [FLUSH_CNT_W-1:0] flush_cnt;
    logic                   flush_br;
    logic                   redirect_q;

    logic                   apply;
    logic [ADDR_W-1:0]      sel_target;
    pri_t                   sel_pri;
    logic [ADDR_W-1:0]      new_pc;
    logic                   new_br;

    jump_decode #(.ADDR_W(ADDR_W)) u_decode (
        .idInstr   (bus.idInstr),
        .idValid   (bus.idValid),
        .idPc      (bus.idPc),
        .regRs     (bus.regRs),
        .brTaken   (bus.brTaken),
        .brTarget  (bus.brTarget),
        .reqValid  (req_valid),
        .reqPri    (req_pri),
        .reqTarget (req_target)
    );

    // On release from HOLD only a strictly higher-priority live request beats the held one
    always_comb begin
        apply      = 1'b0;
        sel_target = req_target;
        sel_pri    = req_pri;
        if (state == ST_RUN) begin
            apply = !bus.stall && req_valid;
        end else begin
            apply = !bus.stall;
            if (!(req_valid && req_pri > pend_pri)) begin
                sel_target = pend_target;
                sel_pri    = pend_pri;
            end
        end
    end

`ifdef PC_REDIRECT_ALIGN_CHECK_EN
    logic bad_align;
    logic misalign_q;

    assign bad_align = sel_target[1:0] != 2'b00;
    assign new_pc    = bad_align ? TRAP_VEC : sel_target;
    assign new_br    = bad_align || (sel_pri == PRI_BRANCH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) misalign_q <= 1'b0;
        else       misalign_q <= apply && bad_align;
    end
    assign bus.misalign = misalign_q;
`else
    logic unused_trap;

    assign unused_trap  = ^TRAP_VEC;
    assign new_pc       = sel_target;
    assign new_br       = sel_pri == PRI_BRANCH;
    assign bus.misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            pc_q        <= RESET_PC;
            pend_target <= '0;
            pend_pri    <= PRI_NONE;
            flush_cnt   <= '0;
            flush_br    <= 1'b0;
            redirect_q  <= 1'b0;
        end else begin
            redirect_q <= apply;
            if (apply) begin
                pc_q      <= new_pc;
                flush_cnt <= FLUSH_LOAD;
                flush_br  <= new_br;
            end else begin
                if (state == ST_RUN && !bus.stall) pc_q <= pc_q + PC_STEP;
                if (flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
            end

            case (state)
                ST_RUN: begin
                    if (bus.stall && req_valid) begin
                        pend_target <= req_target;
                        pend_pri    <= req_pri;
                        state       <= ST_HOLD;
                    end
                end
                default: begin
                    if (!bus.stall) begin
                        pend_pri <= PRI_NONE;
                        state    <= ST_RUN;
                    end else if (req_valid && req_pri >= pend_pri) begin
                        pend_target <= req_target;
                        pend_pri    <= req_pri;
                    end
                end
            endcase
        end
    end

    // HOLD keeps flush up so ID never issues down a path that is about to be abandoned
    assign bus.pc       = pc_q;
    assign bus.pcPlus4  = pc_q + PC_STEP;
    assign bus.redirect = redirect_q;
    assign bus.flush    = (flush_cnt != '0) || (state == ST_HOLD);
    assign bus.flushEx  = (flush_cnt != '0) && flush_br;
endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: directed vector table, multi-cycle corner sequences, random run vs reference model.
module tb_pc_redirect_unit;
    localparam int FC = 3;
    localparam logic [31:0] JR_I  = 32'h03E0_0008;
    localparam logic [31:0] J_I   = 32'h0800_0100;
    localparam logic [31:0] NOP_I = 32'h0000_0000;
    localparam logic [31:0] TRAP  = 32'h0000_0080;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_redirect_unit_if #(.ADDR_W(32)) bus();

    pc_redirect_unit #(
        .ADDR_W       (32),
        .RESET_PC     (32'h0),
        .FLUSH_CYCLES (FC),
        .TRAP_VEC     (TRAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        stall;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] idpc;
        logic [31:0] rs;
        logic        bt;
        logic [31:0] btgt;
        logic [31:0] pc;
        logic        redir;
        logic        flush;
        logic        fex;
    } vec_t;

    vec_t vt[30];

    function automatic vec_t mk(logic st, logic [31:0] ins, logic v, logic [31:0] ipc, logic [31:0] rs,
                                logic bt, logic [31:0] btg, logic [31:0] epc, logic er, logic ef, logic efx);
        vec_t t;
        t.stall = st; t.instr = ins; t.valid = v; t.idpc = ipc; t.rs = rs; t.bt = bt; t.btgt = btg;
        t.pc = epc; t.redir = er; t.flush = ef; t.fex = efx;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drv(input logic st, input logic [31:0] ins, input logic v, input logic [31:0] ipc,
                       input logic [31:0] rs, input logic bt, input logic [31:0] btg);
        bus.stall = st; bus.idInstr = ins; bus.idValid = v; bus.idPc = ipc;
        bus.regRs = rs; bus.brTaken = bt; bus.brTarget = btg;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: architectural pc, held redirect, and flush window as an absolute cycle deadline
    logic [31:0] m_pc;
    bit          m_hold;
    logic [31:0] m_ptgt;
    int          m_ppri;
    int          m_cyc;
    int          m_flush_until;
    bit          m_flush_br;
    bit          m_redir;
    bit          m_mis;

    task automatic m_reset();
        m_pc = 32'h0; m_hold = 0; m_ptgt = 0; m_ppri = 0; m_cyc = 0;
        m_flush_until = -1; m_flush_br = 0; m_redir = 0; m_mis = 0;
    endtask

    task automatic m_step(input bit st, input logic [31:0] ins, input bit v, input logic [31:0] ipc,
                          input logic [31:0] rs, input bit bt, input logic [31:0] btg);
        int          rpri;
        logic [31:0] rtgt;
        bit          go;
        int          gpri;
        logic [31:0] gtgt;
        rpri = 0; rtgt = 0; go = 0; gpri = 0; gtgt = 0;
        if (bt) begin
            rpri = 2; rtgt = btg;
        end else if (v && ins[31:26] == 6'd0 && (ins[5:0] == 6'd8 || ins[5:0] == 6'd9)) begin
            rpri = 1; rtgt = rs;
        end else if (v && (ins[31:26] == 6'd2 || ins[31:26] == 6'd3)) begin
            rpri = 1; rtgt = {ipc[31:28], ins[25:0], 2'b00};
        end
        m_cyc++;
        m_redir = 0;
        m_mis = 0;
        if (m_hold) begin
            if (!st) begin
                go = 1; m_hold = 0;
                if (rpri > m_ppri) begin gtgt = rtgt; gpri = rpri; end
                else begin gtgt = m_ptgt; gpri = m_ppri; end
            end else if (rpri != 0 && rpri >= m_ppri) begin
                m_ptgt = rtgt; m_ppri = rpri;
            end
        end else if (!st) begin
            if (rpri != 0) begin go = 1; gtgt = rtgt; gpri = rpri; end
            else m_pc = m_pc + 32'd4;
        end else if (rpri != 0) begin
            m_hold = 1; m_ptgt = rtgt; m_ppri = rpri;
        end
        if (go) begin
            m_redir = 1;
            m_flush_br = (gpri == 2);
`ifdef PC_REDIRECT_ALIGN_CHECK_EN
            if (gtgt[1:0] != 2'b00) begin
                gtgt = TRAP; m_mis = 1; m_flush_br = 1;
            end
`endif
            m_pc = gtgt;
            m_flush_until = m_cyc + FC - 1;
        end
    endtask

    task automatic check_model();
        chk("rnd_pc", bus.pc, m_pc);
        chk("rnd_pcPlus4", bus.pcPlus4, m_pc + 32'd4);
        chk("rnd_redirect", {31'd0, bus.redirect}, {31'd0, m_redir});
        chk("rnd_flush", {31'd0, bus.flush}, {31'd0, (m_hold || m_cyc <= m_flush_until)});
        chk("rnd_flushEx", {31'd0, bus.flushEx}, {31'd0, (m_cyc <= m_flush_until) && m_flush_br});
        chk("rnd_misalign", {31'd0, bus.misalign}, {31'd0, m_mis});
    endtask

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    initial begin
        logic [31:0] ins;
        logic [31:0] exp_pc;
        logic        exp_mis;

        // vectors from reset; FC=3 so each redirect flushes three cycles
        vt[0]  = mk(0, NOP_I, 0, 0, 0, 0, 0, 32'h4, 0, 0, 0);
        vt[1]  = mk(0, NOP_I, 0, 0, 0, 0, 0, 32'h8, 0, 0, 0);
        vt[2]  = mk(0, NOP_I, 0, 0, 0, 0, 0, 32'hC, 0, 0, 0);
        vt[3]  = mk(0, JR_I, 1, 32'h40, 32'h1000, 0, 0, 32'h1000, 1, 1, 0);
        vt[4]  = mk(0, NOP_I, 0, 0, 0, 0, 0, 32'h1004, 0, 1, 0);
        vt[5]  = mk(0, NOP_I, 0, 0, 0, 0, 0, 32'h1008, 0, 1, 0);
        vt[6]  = mk(0, NOP_I, 0, 0, 0, 0, 0, 32'h100C, 0, 0, 0);
        vt[7]  = mk(0, JR_I, 0, 32'h40, 32'h1000, 0, 0, 32'h1010, 0, 0, 0);
        vt[8]  = mk(0, JR_I, 1, 32'h40, 32'h1000, 1, 32'h3000, 32'h3000, 1, 1, 1);
        vt[9]  = mk(0, NOP_I, 0, 0, 0, 0, 0, 32'h3004, 0, 1, 1);
        vt[10] = mk(0, J_I, 1, 32'h3000, 0, 0, 0, 32'h400, 1, 1, 0);
        vt[11] = mk(0, NOP_I, 0, 0, 0, 0, 0, 32'h404, 0, 1, 0);
        vt[12] = mk(0, NOP_I, 0, 0, 0, 0, 0, 32'h408, 0, 1, 0);
        vt[13] = mk(0, NOP_I, 0, 0, 0, 0, 0, 32'h40C, 0, 0, 0);
        vt[14] = mk(1, J_I, 1, 32'h400, 0, 0, 0, 32'h40C, 0, 1, 0);
        vt[15] = mk(1, NOP_I, 0, 0, 0, 0, 0, 32'h40C, 0, 1, 0);
        vt[16] = mk(1, NOP_I, 0, 0, 0, 0, 0, 32'h40C, 0, 1, 0);
        vt[17] = mk(0, NOP_I, 0, 0, 0, 0, 0, 32'h400, 1, 1, 0);
        vt[18] = mk(0, NOP_I, 0, 0, 0, 0, 0, 32'h404, 0, 1, 0);
        vt[19] = mk(0, NOP_I, 0, 0, 0, 0, 0, 32'h408, 0, 1, 0);
        vt[20] = mk(0, NOP_I, 0, 0, 0, 0, 0, 32'h40C, 0, 0, 0);
        vt[21] = mk(1, JR_I, 1, 32'h40, 32'h2000, 0, 0, 32'h40C, 0, 1, 0);
        vt[22] = mk(1, NOP_I, 0, 0, 0, 1, 32'h3000, 32'h40C, 0, 1, 0);
        vt[23] = mk(1, J_I, 1, 32'h5000_0000, 0, 0, 0, 32'h40C, 0, 1, 0);
        vt[24] = mk(0, NOP_I, 0, 0, 0, 0, 0, 32'h3000, 1, 1, 1);
        vt[25] = mk(0, NOP_I, 0, 0, 0, 0, 0, 32'h3004, 0, 1, 1);
        vt[26] = mk(0, NOP_I, 0, 0, 0, 0, 0, 32'h3008, 0, 1, 1);
        vt[27] = mk(0, NOP_I, 0, 0, 0, 0, 0, 32'h300C, 0, 0, 0);
        vt[28] = mk(0, JR_I, 1, 0, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 1, 0);
        vt[29] = mk(0, NOP_I, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0);

        reset = 1'b1;
        drv(0, NOP_I, 0, 0, 0, 0, 0);
        repeat (2) tick();
        chk("reset_pc", bus.pc, 32'h0);
        chk("reset_pcPlus4", bus.pcPlus4, 32'h4);
        chk("reset_outs", {28'd0, bus.redirect, bus.flush, bus.flushEx, bus.misalign}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 30; i++) begin
            drv(vt[i].stall, vt[i].instr, vt[i].valid, vt[i].idpc, vt[i].rs, vt[i].bt, vt[i].btgt);
            tick();
            chk($sformatf("vec%0d_pc", i), bus.pc, vt[i].pc);
            chk($sformatf("vec%0d_pcPlus4", i), bus.pcPlus4, vt[i].pc + 32'd4);
            chk($sformatf("vec%0d_redirect", i), {31'd0, bus.redirect}, {31'd0, vt[i].redir});
            chk($sformatf("vec%0d_flush", i), {31'd0, bus.flush}, {31'd0, vt[i].flush});
            chk($sformatf("vec%0d_flushEx", i), {31'd0, bus.flushEx}, {31'd0, vt[i].fex});
            chk($sformatf("vec%0d_misalign", i), {31'd0, bus.misalign}, 32'd0);
        end

        // async reset while holding a redirect discards it
        drv(0, NOP_I, 0, 0, 0, 0, 0);
        tick();
        drv(1, JR_I, 1, 32'h40, 32'h2000, 0, 0);
        tick();
        chk("hold_pc", bus.pc, 32'h4);
        chk("hold_flush", {31'd0, bus.flush}, 32'd1);
        reset = 1'b1;
        #2;
        chk("async_reset_pc", bus.pc, 32'h0);
        chk("async_reset_flush", {31'd0, bus.flush}, 32'd0);
        tick();
        drv(0, NOP_I, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        chk("post_reset_pc", bus.pc, 32'h4);
        chk("post_reset_redirect", {31'd0, bus.redirect}, 32'd0);

        // misaligned register target
`ifdef PC_REDIRECT_ALIGN_CHECK_EN
        exp_pc = TRAP; exp_mis = 1'b1;
`else
        exp_pc = 32'h1002; exp_mis = 1'b0;
`endif
        drv(0, JR_I, 1, 32'h40, 32'h1002, 0, 0);
        tick();
        chk("mis_pc", bus.pc, exp_pc);
        chk("mis_misalign", {31'd0, bus.misalign}, {31'd0, exp_mis});
        chk("mis_flushEx", {31'd0, bus.flushEx}, {31'd0, exp_mis});
        chk("mis_redirect", {31'd0, bus.redirect}, 32'd1);
        drv(0, NOP_I, 0, 0, 0, 0, 0);
        tick();
        chk("mis_pulse_end", {31'd0, bus.misalign}, 32'd0);

        // branch arriving in the release cycle beats the held JR
        drv(1, JR_I, 1, 32'h40, 32'h2000, 0, 0);
        tick();
        drv(0, NOP_I, 0, 0, 0, 1, 32'h5000);
        tick();
        chk("rel_br_pc", bus.pc, 32'h5000);
        chk("rel_br_flushEx", {31'd0, bus.flushEx}, 32'd1);
        chk("rel_br_redirect", {31'd0, bus.redirect}, 32'd1);

        // randomized run against the reference model
        reset = 1'b1;
        #2;
        m_reset();
        check_model();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                reset = 1'b1;
                #2;
                m_reset();
                check_model();
                tick();
                reset = 1'b0;
            end
            case ($urandom_range(0, 5))
                0:       ins = {6'd0, 5'($urandom), 15'd0, 6'd8};
                1:       ins = {6'd0, 5'($urandom), 15'd0, 6'd9};
                2:       ins = {6'd2, 26'($urandom)};
                3:       ins = {6'd3, 26'($urandom)};
                default: ins = $urandom;
            endcase
            drv($urandom_range(0, 9) < 3, ins, $urandom_range(0, 3) != 0, $urandom,
                rand_tgt(), $urandom_range(0, 6) == 0, rand_tgt());
            m_step(bus.stall, bus.idInstr, bus.idValid, bus.idPc, bus.regRs, bus.brTaken, bus.brTarget);
            tick();
            check_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Parametrised successor to the decode-stage jump-register select. Owns the fetch PC register.
- Arbitrates the next PC between:
  - sequential PC+4,
  - J/JAL targets,
  - JR/JALR register targets,
  - EX-stage taken branches.
- Holds a redirect that arrives during a fetch stall and applies it when the stall releases.
- Generates a multi-cycle pipeline flush. Sits between the IF PC register and the ID/EX stages.

Parameters:
- ADDR_W, 32, PC and target width (≥ 28)
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- FLUSH_CYCLES, 1, cycles flush_o stays high per redirect (1..7)
- TRAP_VEC, 32'h0000_0080, misaligned-target vector (used only with the optional feature)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- stall  in  1  fetch stall; PC must not advance while high
- idInstr  in  32  instruction currently in ID
- idValid  in  1  idInstr is a real (not bubble) instruction
- idPc  in  ADDR_W  PC of idInstr
- regRs  in  ADDR_W  forwarded rs value for JR/JALR
- brTaken  in  1  EX-stage branch resolved taken
- brTarget  in  ADDR_W  EX-stage branch target
- pc  out  ADDR_W  current fetch PC (registered)
- pcPlus4  out  ADDR_W  pc+4, modulo 2^ADDR_W
- redirect  out  1  one-cycle pulse: a redirect was applied to pc this edge
- flush  out  1  squash IF/ID (and ID/EX when the source is a branch)
- flushEx  out  1  high alongside flush only for branch-sourced redirects
- misalign  out  1  one-cycle pulse (ALIGN_CHECK_EN only; tied 0 otherwise)

Behaviour:
- Reset (async, active-high) values:
  - pc=RESET_PC
  - redirect=0, flush=0, flushEx=0, misalign=0
  - state=RUN, flush counter=0, pending cleared
- Decode, valid only when idValid=1:
  - JR: op=000000, funct=001000 → target regRs
  - JALR: op=000000, funct=001001 → target regRs
  - J / JAL: op=000010 / 000011 → target {idPc[ADDR_W-1:28], idInstr[25:0], 2'b00}
- Priority: brTaken (priority 2) > JR/JALR (priority 1) > J/JAL (priority 1) > sequential.
- States:
  - RUN:
    - no stall: pc <= selected target if any request is active, else pc+4.
    - stall with a request: latch target and priority into pending; go to HOLD; pc unchanged.
  - HOLD:
    - pc frozen.
    - A new request overwrites pending only if its priority ≥ the stored priority.
    - On stall=0: pc <= pending target (a same-cycle request of higher priority wins); return to RUN.
    - On reset: back to RUN; pending discarded.
- Redirect application (the edge pc takes a non-sequential target):
  - redirect=1 for exactly the following cycle.
  - flush=1 for FLUSH_CYCLES cycles starting in that same cycle.
  - flushEx follows flush only when the source was a branch.
  - flush is also driven high while in HOLD, so ID cannot issue a wrong-path instruction.
- A redirect during an active flush window reloads the counter to FLUSH_CYCLES; the target is replaced, never merged.
- Arithmetic: pcPlus4 wraps at 2^ADDR_W (e.g. all-ones−3 → 0); no saturation.
- Latency: request in cycle N with stall=0 → pc updated at edge N+1.

Optional Feature:
- Macro: PC_REDIRECT_ALIGN_CHECK_EN.
- Defined:
  - Any applied redirect target with bits [1:0] ≠ 0 loads pc=TRAP_VEC instead.
  - misalign pulses 1 cycle; flush and flushEx behave as for a branch.
- Undefined:
  - Targets are applied unchanged.
  - misalign is constant 0.
  - No comparator logic is synthesised.

Decomposition:
- Shared package holds:
  - opcode/funct localparams (OP_RTYPE, OP_J, OP_JAL, FN_JR, FN_JALR)
  - state encoding RUN/HOLD
  - priority encoding constants
- One natural sub-module: jump_decode. Combinational; decodes idInstr into reqValid, reqPri and reqTarget. Reusable by the hazard unit.

Test Plan:
- Reset with pc running, then 4 free cycles → pc = 0, 4, 8, 12. redirect=0, flush=0 throughout.
- JR at idPc=0x40 with regRs=0x1000, no stall → next pc=0x1000; redirect pulses 1 cycle; flush high for FLUSH_CYCLES; flushEx=0.
- J with idInstr=0x08000100 and stall held 3 cycles → pc frozen, flush high during HOLD; after release pc=0x400.
- HOLD holding a JR target 0x2000, then brTaken with brTarget=0x3000 → after release pc=0x3000 and flushEx=1. A later J while still in HOLD does not overwrite 0x3000.
- brTaken and JR in the same cycle → branch target wins. JR with idValid=0 → ignored; pc+4.
- PC_REDIRECT_ALIGN_CHECK_EN defined, JR to 0x1002 → pc=TRAP_VEC (0x80), misalign pulses once. Macro undefined → pc=0x1002.
